atm_session_ctrl: RTL and testbench

Session controller that sits directly upstream of `authenticator` in the CryptoATM datapath. It accepts a card (account number) and a PIN from the front panel, and drives `authenticator`'s `acc_number`, `pin`, `action` and `deAuth` inputs. After a fixed settle time it samples `wasSuccessful`/`accIndex` and owns the resulting session: retry counting, lockout, inactivity timeout and logout.

---
 rtl/atm_session_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_atm_session_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/atm_session_ctrl.sv
// Session controller in front of the CryptoATM authenticator: card lookup, PIN
// retries with lockout, inactivity timeout and logout with a one-cycle deAuth.
module atm_session_ctrl #(
    parameter int MAX_TRIES    = 3,
    parameter int LOCK_CYCLES  = 16,
    parameter int IDLE_TIMEOUT = 1000,
    parameter int AUTH_WAIT    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        card_valid,
    input  logic [15:0] card_number,
    input  logic        pin_valid,
    input  logic [15:0] pin_entry,
    input  logic        activity,
    input  logic        logout,
    output logic [15:0] auth_acc_number,
    output logic [15:0] auth_pin,
    output logic        auth_action,
    output logic        auth_deAuth,
    input  logic        auth_wasSuccessful,
    input  logic [3:0]  auth_accIndex,
    output logic        session_active,
    output logic [3:0]  session_index,
    output logic [3:0]  tries_left,
    output logic [2:0]  status
);

    localparam int IW = $clog2(IDLE_TIMEOUT + 1);
    localparam int WW = $clog2(AUTH_WAIT + 1);
    localparam int LW = $clog2(LOCK_CYCLES + 1);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_FIND_WAIT = 3'd1;
    localparam logic [2:0] S_PIN_ENTRY = 3'd2;
    localparam logic [2:0] S_AUTH_WAIT = 3'd3;
    localparam logic [2:0] S_SESSION   = 3'd4;
    localparam logic [2:0] S_LOCKED    = 3'd5;
    localparam logic [2:0] S_DEAUTH    = 3'd6;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_BUSY    = 3'd1;
    localparam logic [2:0] ST_CARD_OK = 3'd2;
    localparam logic [2:0] ST_REJECT  = 3'd3;
    localparam logic [2:0] ST_PIN_BAD = 3'd4;
    localparam logic [2:0] ST_LOCKED  = 3'd5;
    localparam logic [2:0] ST_SESSION = 3'd6;
    localparam logic [2:0] ST_TIMEOUT = 3'd7;

    localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_TIMEOUT - 1);

    logic [2:0]    state;
    logic [WW-1:0] wait_cnt;
    logic [LW-1:0] lock_cnt;
    logic [IW-1:0] idle_cnt;
    logic          idle_touch;
    logic          idle_expire;
    logic          auth_ok;
    logic          wait_done;

    assign idle_touch  = activity | pin_valid;
    // Expiry fires on the edge where the timer would reach IDLE_TIMEOUT.
    assign idle_expire = !idle_touch && (idle_cnt == IDLE_LAST);
    // x/z from the authenticator must not count as success.
    assign auth_ok     = (auth_wasSuccessful == 1'b1);
    assign wait_done   = (wait_cnt == WW'(1));

    assign auth_deAuth    = (state == S_DEAUTH);
    assign session_active = (state == S_SESSION);

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= S_IDLE;
            wait_cnt        <= '0;
            lock_cnt        <= '0;
            idle_cnt        <= '0;
            auth_acc_number <= '0;
            auth_pin        <= '0;
            auth_action     <= 1'b0;
            session_index   <= '0;
            tries_left      <= '0;
            status          <= ST_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (card_valid) begin
                        auth_acc_number <= card_number;
                        auth_action     <= 1'b0;
                        wait_cnt        <= WW'(AUTH_WAIT);
                        status          <= ST_BUSY;
                        state           <= S_FIND_WAIT;
                    end
                end
                S_FIND_WAIT: begin
                    wait_cnt <= wait_cnt - 1'b1;
                    if (wait_done) begin
                        if (auth_ok) begin
                            tries_left <= 4'(MAX_TRIES);
                            idle_cnt   <= '0;
                            status     <= ST_CARD_OK;
                            state      <= S_PIN_ENTRY;
                        end else begin
                            status <= ST_REJECT;
                            state  <= S_IDLE;
                        end
                    end
                end
                S_PIN_ENTRY: begin
                    if (pin_valid) begin
                        auth_pin    <= pin_entry;
                        auth_action <= 1'b1;
                        wait_cnt    <= WW'(AUTH_WAIT);
                        idle_cnt    <= '0;
                        status      <= ST_BUSY;
                        state       <= S_AUTH_WAIT;
                    end else if (idle_expire) begin
                        status <= ST_TIMEOUT;
                        state  <= S_DEAUTH;
                    end else if (activity) begin
                        idle_cnt <= '0;
                    end else begin
                        idle_cnt <= idle_cnt + 1'b1;
                    end
                end
                S_AUTH_WAIT: begin
                    wait_cnt <= wait_cnt - 1'b1;
                    if (wait_done) begin
                        if (auth_ok) begin
                            session_index <= auth_accIndex;
                            idle_cnt      <= '0;
                            status        <= ST_SESSION;
                            state         <= S_SESSION;
                        end else begin
                            tries_left <= tries_left - 4'd1;
                            if (tries_left == 4'd1) begin
                                lock_cnt <= LW'(LOCK_CYCLES);
                                status   <= ST_LOCKED;
                                state    <= S_LOCKED;
                            end else begin
                                idle_cnt <= '0;
                                status   <= ST_PIN_BAD;
                                state    <= S_PIN_ENTRY;
                            end
                        end
                    end
                end
                S_SESSION: begin
                    if (logout) begin
                        status <= ST_IDLE;
                        state  <= S_DEAUTH;
                    end else if (idle_expire) begin
                        status <= ST_TIMEOUT;
                        state  <= S_DEAUTH;
                    end else if (idle_touch) begin
                        idle_cnt <= '0;
                    end else begin
                        idle_cnt <= idle_cnt + 1'b1;
                    end
                end
                S_LOCKED: begin
                    if (lock_cnt == '0) begin
                        state <= S_DEAUTH;
                    end else begin
                        lock_cnt <= lock_cnt - 1'b1;
                    end
                end
                S_DEAUTH: begin
                    auth_acc_number <= '0;
                    auth_pin        <= '0;
                    auth_action     <= 1'b0;
                    session_index   <= '0;
                    tries_left      <= '0;
                    idle_cnt        <= '0;
                    state           <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_atm_session_ctrl.sv
// Directed bench for atm_session_ctrl with a behavioural authenticator and a
// scoreboard of expected decisions.
module tb_atm_session_ctrl;

    localparam int MT = 3;
    localparam int LC = 16;
    localparam int IT = 20;
    localparam int AW = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        card_valid;
    logic [15:0] card_number;
    logic        pin_valid;
    logic [15:0] pin_entry;
    logic        activity;
    logic        logout;
    logic [15:0] auth_acc_number;
    logic [15:0] auth_pin;
    logic        auth_action;
    logic        auth_deAuth;
    logic        auth_wasSuccessful;
    logic [3:0]  auth_accIndex;
    logic        session_active;
    logic [3:0]  session_index;
    logic [3:0]  tries_left;
    logic [2:0]  status;

    int checks = 0;
    int failures = 0;

    typedef struct {
        string      tag;
        logic [2:0] st;
        logic [3:0] tries;
        logic       active;
        logic [3:0] index;
    } exp_t;

    exp_t sb[$];

    atm_session_ctrl #(
        .MAX_TRIES(MT),
        .LOCK_CYCLES(LC),
        .IDLE_TIMEOUT(IT),
        .AUTH_WAIT(AW)
    ) dut (
        .clk(clk),
        .reset(reset),
        .card_valid(card_valid),
        .card_number(card_number),
        .pin_valid(pin_valid),
        .pin_entry(pin_entry),
        .activity(activity),
        .logout(logout),
        .auth_acc_number(auth_acc_number),
        .auth_pin(auth_pin),
        .auth_action(auth_action),
        .auth_deAuth(auth_deAuth),
        .auth_wasSuccessful(auth_wasSuccessful),
        .auth_accIndex(auth_accIndex),
        .session_active(session_active),
        .session_index(session_index),
        .tries_left(tries_left),
        .status(status)
    );

    always #5 clk = ~clk;

    // Authenticator stand-in: 2749/0 idx0, 2175/1 idx1, 2429/3 idx2, 2910/7 idx3.
    logic        db_found;
    logic [15:0] db_pin;
    always_comb begin
        db_found      = 1'b1;
        db_pin        = 16'd0;
        auth_accIndex = 4'd0;
        case (auth_acc_number)
            16'd2749: begin db_pin = 16'd0; auth_accIndex = 4'd0; end
            16'd2175: begin db_pin = 16'd1; auth_accIndex = 4'd1; end
            16'd2429: begin db_pin = 16'd3; auth_accIndex = 4'd2; end
            16'd2910: begin db_pin = 16'd7; auth_accIndex = 4'd3; end
            default:  db_found = 1'b0;
        endcase
        auth_wasSuccessful = auth_action ? (db_found && (auth_pin == db_pin)) : db_found;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic push(input string tag, input logic [2:0] st, input logic [3:0] tries,
                        input logic active, input logic [3:0] index);
        exp_t e;
        e.tag = tag; e.st = st; e.tries = tries; e.active = active; e.index = index;
        sb.push_back(e);
    endtask

    task automatic card(input logic [15:0] num);
        card_valid = 1'b1; card_number = num;
        step();
        card_valid = 1'b0;
        chk("card_busy", status, 3'd1);
        chk("card_acc", auth_acc_number, num);
        chk("card_action", auth_action, 1'b0);
    endtask

    task automatic pin(input logic [15:0] p);
        pin_valid = 1'b1; pin_entry = p;
        step();
        pin_valid = 1'b0;
        chk("pin_busy", status, 3'd1);
        chk("pin_value", auth_pin, p);
        chk("pin_action", auth_action, 1'b1);
    endtask

    // Decision lands AUTH_WAIT edges after the accepting edge.
    task automatic decide();
        exp_t e;
        checks++;
        assert (sb.size() > 0) else begin
            failures++;
            $error("FAIL sb_empty observed=0 expected=nonzero");
        end
        if (sb.size() > 0) begin
            e = sb.pop_front();
            for (int i = 1; i < AW; i++) begin
                step();
                chk({e.tag, "_still_busy"}, status, 3'd1);
            end
            step();
            chk({e.tag, "_status"}, status, e.st);
            chk({e.tag, "_tries"}, tries_left, e.tries);
            chk({e.tag, "_active"}, session_active, e.active);
            if (e.active) chk({e.tag, "_index"}, session_index, e.index);
            chk({e.tag, "_deauth"}, auth_deAuth, 1'b0);
        end
    endtask

    task automatic chk_cleared(input string tag);
        chk({tag, "_deauth_low"}, auth_deAuth, 1'b0);
        chk({tag, "_acc_clr"}, auth_acc_number, 16'd0);
        chk({tag, "_pin_clr"}, auth_pin, 16'd0);
        chk({tag, "_action_clr"}, auth_action, 1'b0);
        chk({tag, "_tries_clr"}, tries_left, 4'd0);
        chk({tag, "_index_clr"}, session_index, 4'd0);
        chk({tag, "_active_clr"}, session_active, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; card_valid = 1'b0; card_number = '0; pin_valid = 1'b0;
        pin_entry = '0; activity = 1'b0; logout = 1'b0;
        step(); step();
        reset = 1'b0;
        chk("rst_status", status, 3'd0);
        chk_cleared("rst");

        // Good card, good PIN, logout.
        push("find2175", 3'd2, 4'd3, 1'b0, 4'd0);
        card(16'd2175);
        decide();
        push("auth2175", 3'd6, 4'd3, 1'b1, 4'd1);
        pin(16'd1);
        decide();
        logout = 1'b1;
        step();
        logout = 1'b0;
        chk("logout_deauth", auth_deAuth, 1'b1);
        chk("logout_active", session_active, 1'b0);
        chk("logout_status", status, 3'd0);
        step();
        chk_cleared("logout");
        chk("logout_idle_status", status, 3'd0);

        // Stray PIN in IDLE is ignored.
        pin_valid = 1'b1; pin_entry = 16'd5;
        step();
        pin_valid = 1'b0;
        chk("stray_pin_status", status, 3'd0);
        chk("stray_pin_value", auth_pin, 16'd0);

        // Unknown card.
        push("find1234", 3'd3, 4'd0, 1'b0, 4'd0);
        card(16'd1234);
        decide();
        step();
        chk("reject_no_deauth", auth_deAuth, 1'b0);
        chk("reject_hold", status, 3'd3);

        // Three wrong PINs then lockout.
        push("find2429", 3'd2, 4'd3, 1'b0, 4'd0);
        card(16'd2429);
        decide();
        push("bad1", 3'd4, 4'd2, 1'b0, 4'd0);
        pin(16'd7);
        decide();
        push("bad2", 3'd4, 4'd1, 1'b0, 4'd0);
        pin(16'd7);
        decide();
        push("bad3", 3'd5, 4'd0, 1'b0, 4'd0);
        pin(16'd7);
        decide();
        for (int k = 1; k <= LC; k++) begin
            if (k == 3) begin card_valid = 1'b1; card_number = 16'd2175; end
            step();
            card_valid = 1'b0;
            chk("lock_no_deauth", auth_deAuth, 1'b0);
            chk("lock_status", status, 3'd5);
        end
        step();
        chk("lock_deauth", auth_deAuth, 1'b1);
        chk("lock_deauth_status", status, 3'd5);
        step();
        chk_cleared("lock_idle");
        chk("lock_idle_status", status, 3'd5);

        // Session inactivity timeout with one activity keepalive.
        push("find2910", 3'd2, 4'd3, 1'b0, 4'd0);
        card(16'd2910);
        decide();
        push("auth2910", 3'd6, 4'd3, 1'b1, 4'd3);
        pin(16'd7);
        decide();
        for (int k = 1; k <= 14; k++) step();
        chk("pre_activity_active", session_active, 1'b1);
        activity = 1'b1;
        step();
        activity = 1'b0;
        for (int k = 1; k < IT; k++) begin
            step();
            chk("keepalive_status", status, 3'd6);
        end
        step();
        chk("timeout_status", status, 3'd7);
        chk("timeout_deauth", auth_deAuth, 1'b1);
        chk("timeout_active", session_active, 1'b0);
        step();
        chk_cleared("timeout_idle");

        // PIN_ENTRY timeout; logout there is ignored.
        push("find2910b", 3'd2, 4'd3, 1'b0, 4'd0);
        card(16'd2910);
        decide();
        logout = 1'b1;
        step();
        logout = 1'b0;
        chk("pin_logout_ignored", status, 3'd2);
        for (int k = 2; k < IT; k++) step();
        chk("pin_pre_timeout", status, 3'd2);
        step();
        chk("pin_timeout_status", status, 3'd7);
        chk("pin_timeout_deauth", auth_deAuth, 1'b1);
        step();

        // Logout coincides with timeout.
        push("find2175b", 3'd2, 4'd3, 1'b0, 4'd0);
        card(16'd2175);
        decide();
        push("auth2175b", 3'd6, 4'd3, 1'b1, 4'd1);
        pin(16'd1);
        decide();
        for (int k = 1; k < IT; k++) step();
        chk("race_pre_status", status, 3'd6);
        logout = 1'b1;
        step();
        logout = 1'b0;
        chk("race_status", status, 3'd0);
        chk("race_deauth", auth_deAuth, 1'b1);
        step();

        // Reset during AUTH_WAIT_S.
        push("find2749", 3'd2, 4'd3, 1'b0, 4'd0);
        card(16'd2749);
        decide();
        pin(16'd0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("midrst_status", status, 3'd0);
        chk_cleared("midrst");
        step();
        chk("midrst_no_deauth", auth_deAuth, 1'b0);

        push("find2749b", 3'd2, 4'd3, 1'b0, 4'd0);
        card(16'd2749);
        decide();
        push("auth2749", 3'd6, 4'd3, 1'b1, 4'd0);
        pin(16'd0);
        decide();

        chk("sb_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
